freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 160 ++++++++++++++++
 tb/tb_freq_meter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//
// Measures the period and high time of a slow asynchronous signal in units of
// speed_clock cycles. The signal is synchronised, its rising edges are
// detected, and the cycles between consecutive rises are counted. A watchdog
// declares a timeout if no rise is seen for TIMEOUT cycles.
//
// Parameters
//   CNT_W    width of the period/high counters and count outputs
//   TIMEOUT  cycles without a detected rise before timeout is declared
//
// Ports
//   speed_clock   in   measurement clock; all state updates on its rising edge
//   reset         in   asynchronous, active-high reset
//   signal_in     in   slow asynchronous signal under measurement
//   period_count  out  last measured period in speed_clock cycles (saturating)
//   high_count    out  high cycles within the last measured period (saturating)
//   period_valid  out  one-cycle pulse when period_count/high_count update
//   timeout       out  level, high while no rise seen for TIMEOUT cycles
//   locked        out  high after a full period measured and no timeout since
// ---------------------------------------------------------------------------
module freq_meter #(
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 50000000
) (
    input  logic             speed_clock,
    input  logic             reset,
    input  logic             signal_in,
    output logic [CNT_W-1:0] period_count,
    output logic [CNT_W-1:0] high_count,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    localparam int               TW      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // The watchdog fires on the edge where the count would reach TIMEOUT.
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [CNT_W-1:0] r_cont;
    logic [CNT_W-1:0] r_hcnt;
    logic [TW-1:0]    r_tcnt;
    logic [CNT_W-1:0] r_period_count;
    logic [CNT_W-1:0] r_high_count;
    logic             r_period_valid;
    logic             r_timeout;
    logic             r_locked;

    logic             w_rise;
    logic             w_tout_hit;
    logic [CNT_W-1:0] w_cont_inc;
    logic [CNT_W-1:0] w_hcnt_add;

    // Two-flop synchroniser plus a third flop used only for edge detection.
    always_ff @(posedge speed_clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= signal_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_tout_hit = (r_tcnt == T_LAST);

    // Saturating increments. r_cont/r_hcnt exclude the current cycle, so on a
    // rise these also give the reported values: the rise cycle closes the
    // period, and sync2 is 1 in the rise cycle that opened it.
    assign w_cont_inc = (r_cont == CNT_MAX) ? CNT_MAX : r_cont + CNT_W'(1);
    assign w_hcnt_add = (r_hcnt == CNT_MAX || !r_sync2) ? r_hcnt
                                                        : r_hcnt + CNT_W'(1);

    // Measurement FSM with registered outputs. A rise always beats the
    // watchdog when both happen on the same edge.
    always_ff @(posedge speed_clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cont         <= '0;
            r_hcnt         <= '0;
            r_tcnt         <= '0;
            r_period_count <= '0;
            r_high_count   <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cont  <= '0;
                    r_hcnt  <= '0;
                    r_tcnt  <= '0;
                    r_state <= ARM;
                end
                ARM: begin
                    if (w_rise) begin
                        r_cont    <= '0;
                        r_hcnt    <= '0;
                        r_tcnt    <= '0;
                        r_timeout <= 1'b0;
                        r_state   <= MEASURE;
                    end else if (w_tout_hit) begin
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_tcnt    <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_period_count <= w_cont_inc;
                        r_high_count   <= w_hcnt_add;
                        r_period_valid <= 1'b1;
                        r_locked       <= 1'b1;
                        r_timeout      <= 1'b0;
                        r_cont         <= '0;
                        r_hcnt         <= '0;
                        r_tcnt         <= '0;
                    end else if (w_tout_hit) begin
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_tcnt    <= '0;
                        r_state   <= ARM;
                    end else begin
                        r_cont <= w_cont_inc;
                        r_hcnt <= w_hcnt_add;
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign period_count = r_period_count;
    assign high_count   = r_high_count;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;
    assign locked       = r_locked;

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
//
// Drives freq_meter (CNT_W=4, TIMEOUT=100) with directed square waves, idle
// stretches, a mid-period reset and random waveforms. signal_in changes on the
// falling clock edge, so a level present at rising edge n reaches sync2 at
// edge n+2. The reference model works from the recorded input history: a rise
// is detected at edge m when the input was 1 at m-2 and 0 at m-3; periods are
// differences of rise edges and high counts are sums over the recorded input.
// ---------------------------------------------------------------------------
module tb_freq_meter;

    localparam int CW   = 4;
    localparam int TO   = 100;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HSZ  = 16384;

    logic          speed_clock = 1'b0;
    logic          reset;
    logic          signal_in;
    logic [CW-1:0] period_count;
    logic [CW-1:0] high_count;
    logic          period_valid;
    logic          timeout;
    logic          locked;

    int   errors = 0;
    int   checks = 0;
    int   m;
    logic hist [HSZ];
    int   validSeen;

    // Model state
    int   mPrev;
    int   mRef;
    bit   mHave;
    logic expValid;
    logic expTimeout;
    logic expLocked;
    int   expPeriod;
    int   expHigh;

    freq_meter #(
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .speed_clock (speed_clock),
        .reset       (reset),
        .signal_in   (signal_in),
        .period_count(period_count),
        .high_count  (high_count),
        .period_valid(period_valid),
        .timeout     (timeout),
        .locked      (locked)
    );

    always #5 speed_clock = ~speed_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s edge=%0d observed=%0d expected=%0d",
                   tag, m, observed, expected);
        end
    endtask

    function automatic logic lvl(int k);
        if (k <= 0 || k >= HSZ) return 1'b0;
        return hist[k];
    endfunction

    function automatic int sat(int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic modelReset();
        m          = 0;
        mPrev      = 0;
        mRef       = 1;
        mHave      = 1'b0;
        expValid   = 1'b0;
        expTimeout = 1'b0;
        expLocked  = 1'b0;
        expPeriod  = 0;
        expHigh    = 0;
    endtask

    // Expected outputs after rising edge m. The watchdog measures edges since
    // the last rise, the last timeout, or leaving reset (edge 1).
    task automatic modelEdge();
        int hi;
        expValid = 1'b0;
        if (m >= 2) begin
            if (lvl(m - 2) && !lvl(m - 3)) begin
                if (mHave) begin
                    hi = 0;
                    for (int j = mPrev; j < m; j++) hi += int'(lvl(j - 2));
                    expValid  = 1'b1;
                    expPeriod = sat(m - mPrev);
                    expHigh   = sat(hi);
                    expLocked = 1'b1;
                end
                mHave      = 1'b1;
                mPrev      = m;
                mRef       = m;
                expTimeout = 1'b0;
            end else if (m - mRef == TO) begin
                expTimeout = 1'b1;
                expLocked  = 1'b0;
                mHave      = 1'b0;
                mRef       = m;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("period_valid", 32'(period_valid), 32'(expValid));
        checkOutput("timeout", 32'(timeout), 32'(expTimeout));
        checkOutput("locked", 32'(locked), 32'(expLocked));
        checkOutput("period_count", 32'(period_count), 32'(expPeriod));
        checkOutput("high_count", 32'(high_count), 32'(expHigh));
        if (period_valid) validSeen++;
    endtask

    // Called at a falling edge: drive one cycle of input, then check.
    task automatic applyStimulus(input logic v);
        signal_in = v;
        @(posedge speed_clock);
        m++;
        if (m < HSZ) hist[m] = v;
        modelEdge();
        @(negedge speed_clock);
        checkAll();
    endtask

    task automatic square(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < per; j++)
                applyStimulus(j < hi);
    endtask

    task automatic holdLevel(input logic v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(v);
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_period"}, 32'(period_count), 32'd0);
        checkOutput({tag, "_high"}, 32'(high_count), 32'd0);
        checkOutput({tag, "_valid"}, 32'(period_valid), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        signal_in = 1'b0;
        validSeen = 0;
        modelReset();
        @(negedge speed_clock);
        checkZeros("por");
        repeat (2) @(negedge speed_clock);
        reset = 1'b0;
        modelReset();

        $display("[TB] square wave period 10 high 5");
        validSeen = 0;
        square(10, 5, 4);
        checkOutput("sq10_pulses", validSeen, 3);
        checkOutput("sq10_locked", 32'(locked), 1);
        checkOutput("sq10_period", 32'(period_count), 10);
        checkOutput("sq10_high", 32'(high_count), 5);

        $display("[TB] idle low until timeout, then relock");
        holdLevel(1'b0, 120);
        checkOutput("to_timeout", 32'(timeout), 1);
        checkOutput("to_locked", 32'(locked), 0);
        checkOutput("to_period", 32'(period_count), 10);
        checkOutput("to_high", 32'(high_count), 5);
        square(10, 5, 3);
        checkOutput("relock_locked", 32'(locked), 1);
        checkOutput("relock_timeout", 32'(timeout), 0);

        $display("[TB] rise coincident with watchdog expiry");
        validSeen = 0;
        square(TO, 5, 3);
        checkOutput("coinc_pulses", validSeen, 3);
        checkOutput("coinc_timeout", 32'(timeout), 0);
        checkOutput("coinc_period", 32'(period_count), CMAX);

        $display("[TB] saturated period 20");
        square(20, 7, 4);
        checkOutput("sat_period", 32'(period_count), CMAX);
        checkOutput("sat_high", 32'(high_count), 7);

        $display("[TB] minimum period 2");
        validSeen = 0;
        square(2, 1, 20);
        checkOutput("p2_pulses", validSeen, 19);
        checkOutput("p2_period", 32'(period_count), 2);
        checkOutput("p2_high", 32'(high_count), 1);

        $display("[TB] reset four cycles into a period");
        square(10, 5, 3);
        holdLevel(1'b1, 4);
        reset = 1'b1;
        #1;
        checkZeros("midrst");
        repeat (3) @(negedge speed_clock);
        checkZeros("midrst_hold");
        reset = 1'b0;
        modelReset();
        validSeen = 0;
        square(10, 5, 3);
        checkOutput("postrst_pulses", validSeen, 2);

        $display("[TB] constant low then constant high");
        validSeen = 0;
        holdLevel(1'b0, 150);
        holdLevel(1'b1, 250);
        checkOutput("const_pulses", validSeen, 0);
        checkOutput("const_timeout", 32'(timeout), 1);
        checkOutput("const_locked", 32'(locked), 0);

        $display("[TB] random square waves and gaps");
        for (int i = 0; i < 12; i++) begin
            int per;
            int hi;
            per = int'($urandom_range(2, 24));
            hi  = int'($urandom_range(1, per - 1));
            square(per, hi, int'($urandom_range(2, 5)));
            if ($urandom_range(0, 3) == 0)
                holdLevel(1'b0, int'($urandom_range(20, 130)));
        end

        $display("[TB] random bit stream");
        for (int i = 0; i < 300; i++) applyStimulus(1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
